cross_arb: RTL and testbench
============================

# cross_arb

Shared cross-product unit with round-robin arbitration for the geofence datapath. Up to NREQ engines (hull sort, edge/point side test, self-check) submit signed vector pairs (A, B). The block grants one request per cycle, computes Ax*By − Bx*Ay in a PIPE-stage pipeline, and returns the result with sign flags to the originating requester. It replaces per-engine multiplier pairs with a single time-shared one.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 11, signed operand width (coordinate differences of 10-bit unsigned points)
- PIPE, 2, multiplier pipeline depth in cycles (1..4)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  NREQ  per-requester request strobe
- req_ready  out  NREQ  one-hot grant; transfer when valid&ready
- req_lock  in  NREQ  hold grant across consecutive requests (CROSS_ARB_LOCK_EN only)
- req_ax, req_ay, req_bx, req_by  in  NREQ*W each  packed signed operands, requester i at [i*W +: W]
- rsp_valid  out  NREQ  one-hot result strobe to the originating requester
- rsp_cross  out  2W+1  signed Ax*By − Bx*Ay
- rsp_pos  out  1  rsp_cross > 0
- rsp_zero  out  1  rsp_cross == 0

## Operation
- Arbitration: round-robin pointer ptr. Combinational grant = first i with req_valid[i], searching ptr, ptr+1, …, NREQ−1, 0, … (wrap). req_ready = grant (may depend on req_valid).
- Acceptance: on req_valid[i]&req_ready[i], operands of i are registered into stage 1 with tag i. Requester may change operands the next cycle.
- After acceptance of i: ptr <= i+1 mod NREQ. No acceptance: ptr unchanged.
- Arithmetic: products are 2W-bit signed, full precision; difference sign-extended to 2W+1 bits, never saturated or truncated.
- Response: rsp_valid[tag] pulses exactly one cycle, together with rsp_cross/pos/zero. No response backpressure; requesters must take the result when presented.
- Pipeline is fully pipelined: one acceptance per cycle sustained; in-flight requests returned in acceptance order.
- When rsp_valid is 0, rsp_cross/pos/zero hold their last values.

## Timing
- Reset values: req_ready follows req_valid with ptr=0 (no ready without valid); rsp_valid=0, rsp_cross=0, rsp_pos=0, rsp_zero=1; all pipeline valid bits cleared; ptr=0; lock state cleared.
- Latency: accepted in cycle t -> rsp_valid at the clock edge ending cycle t+PIPE−1, visible in cycle t+PIPE.
- Simultaneous requests: exactly one granted; others wait with req_valid held high (requester must not drop valid while waiting; dropping it is legal but forfeits its turn).
- Response and new acceptance for the same requester in the same cycle are independent and both legal.
- Reset mid-operation: all in-flight results discarded; no rsp_valid after reset release until a new acceptance + PIPE.

## Configuration
- CROSS_ARB_LOCK_EN defined: if the granted requester i is accepted with req_lock[i]=1, the grant is held — ptr frozen, others blocked — until i is accepted with req_lock[i]=0 or drops req_valid. Used for the 6-edge convex sweep.
- Not defined: req_lock ignored (port present, unused); pure round-robin.

## Structure
- Package cross_arb_pkg: default W, PIPE, NREQ constants, derived widths (PROD_W=2W, RES_W=2W+1, TAG_W=$clog2(NREQ)), tag typedef.
- Sub-module rr_arbiter: NREQ-wide rotating-priority grant from req_valid and ptr, returns one-hot grant and encoded index; instantiated once. Lock logic and datapath stay in cross_arb.

## Test plan
- Single requester 0: Ax=3, Ay=0, Bx=0, By=4 -> rsp_valid[0] PIPE cycles later, rsp_cross=12, rsp_pos=1, rsp_zero=0.
- Extremes: Ax=1023, Ay=1023, Bx=−1024, By=1023 -> rsp_cross=2094081; swap A and B -> −2094081, rsp_pos=0.
- Collinear: A=(2,4), B=(1,2) -> rsp_cross=0, rsp_zero=1.
- All 4 requesters valid continuously from reset -> grants 0,1,2,3,0,1…, one per cycle, responses tagged in the same order with no gaps.
- With CROSS_ARB_LOCK_EN: requester 2 issues 6 requests with req_lock=1 for the first 5 while 0,1,3 are valid -> six consecutive grants to 2, then 3,0,1; without macro -> interleaved round-robin.
- Reset asserted with 2 requests in flight -> no rsp_valid after release; ptr=0; next request from 1 returns at +PIPE.

Source files
------------

// File: rtl/cross_arb_pkg.sv
// cross_arb_pkg: shared constants and types for the cross-product arbiter.
// Default sizes, derived product/result/tag widths, and the tag type.
package cross_arb_pkg;

   localparam int NREQ_DEF = 4;
   localparam int W_DEF    = 11;
   localparam int PIPE_DEF = 2;

   localparam int PROD_W = 2 * W_DEF;
   localparam int RES_W  = 2 * W_DEF + 1;
   localparam int TAG_W  = $clog2(NREQ_DEF);

   typedef logic [TAG_W-1:0] tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotating-priority grant, searching from ptr upward with wrap.
// Ports: req (valid bits), ptr (start index) -> grant (one-hot), idx, any.
module rr_arbiter
   import cross_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   localparam int TW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [TW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [TW-1:0]   idx,
   output logic            any
);

   int j;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!any && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = TW'(j);
         end
      end
   end

endmodule

// File: rtl/cross_arb.sv
// cross_arb: time-shared Ax*By - Bx*Ay unit with round-robin request arbitration.
// Ports: clk, reset (async, high); req_valid/ready/lock, packed req_ax/ay/bx/by;
// rsp_valid (one-hot tag), rsp_cross, rsp_pos, rsp_zero.
// Build option CROSS_ARB_LOCK_EN: req_lock holds the grant for burst sweeps.
module cross_arb
   import cross_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int W    = W_DEF,
   parameter int PIPE = PIPE_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ-1:0]     req_lock,
   input  logic [NREQ*W-1:0]   req_ax,
   input  logic [NREQ*W-1:0]   req_ay,
   input  logic [NREQ*W-1:0]   req_bx,
   input  logic [NREQ*W-1:0]   req_by,
   output logic [NREQ-1:0]     rsp_valid,
   output logic signed [2*W:0] rsp_cross,
   output logic                rsp_pos,
   output logic                rsp_zero
);

   localparam int TW = $clog2(NREQ);
   localparam int PW = 2 * W;
   localparam int RW = 2 * W + 1;

   function automatic logic signed [RW-1:0] xprod(
      input logic [W-1:0] ax, input logic [W-1:0] ay,
      input logic [W-1:0] bx, input logic [W-1:0] by);
      logic signed [PW-1:0] p;
      logic signed [PW-1:0] q;
      p = $signed({{W{ax[W-1]}}, ax}) * $signed({{W{by[W-1]}}, by});
      q = $signed({{W{bx[W-1]}}, bx}) * $signed({{W{ay[W-1]}}, ay});
      return $signed({p[PW-1], p}) - $signed({q[PW-1], q});
   endfunction

   logic [TW-1:0]   ptr;
   logic [NREQ-1:0] rr_grant;
   logic [TW-1:0]   rr_idx;
   logic            rr_any;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (rr_grant),
      .idx   (rr_idx),
      .any   (rr_any)
   );

   logic [NREQ-1:0] grant;
   logic [TW-1:0]   gidx;
   logic            gany;
   logic            lock_take;

`ifdef CROSS_ARB_LOCK_EN
   logic          lock_q;
   logic [TW-1:0] lock_idx;
   logic          hold;

   // A lock only survives while its owner keeps requesting.
   assign hold = lock_q && req_valid[lock_idx];

   always_comb begin
      grant = rr_grant;
      gidx  = rr_idx;
      gany  = rr_any;
      if (hold) begin
         grant           = '0;
         grant[lock_idx] = 1'b1;
         gidx            = lock_idx;
         gany            = 1'b1;
      end
   end

   assign lock_take = gany && req_lock[gidx];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock_q   <= 1'b0;
         lock_idx <= '0;
      end else begin
         lock_q <= lock_take;
         if (gany) lock_idx <= gidx;
      end
   end
`else
   logic unused_lock;

   assign unused_lock = ^req_lock;
   assign grant       = rr_grant;
   assign gidx        = rr_idx;
   assign gany        = rr_any;
   assign lock_take   = 1'b0;
`endif

   assign req_ready = grant;

   // Pointer stays frozen while a locked burst is in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else if (gany && !lock_take) begin
         ptr <= (gidx == TW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      end
   end

   logic [W-1:0] g_ax, g_ay, g_bx, g_by;

   assign g_ax = req_ax[int'(gidx)*W +: W];
   assign g_ay = req_ay[int'(gidx)*W +: W];
   assign g_bx = req_bx[int'(gidx)*W +: W];
   assign g_by = req_by[int'(gidx)*W +: W];

   // Head of the pipe: the entry that lands in the output register next.
   logic                 h_v;
   logic [TW-1:0]        h_tag;
   logic signed [RW-1:0] h_cross;

   if (PIPE == 1) begin : g_p1
      assign h_v     = gany;
      assign h_tag   = gidx;
      assign h_cross = xprod(g_ax, g_ay, g_bx, g_by);
   end else begin : g_pn
      logic                 s1_v;
      logic [TW-1:0]        s1_tag;
      logic [W-1:0]         s1_ax, s1_ay, s1_bx, s1_by;
      logic signed [RW-1:0] s1_cross;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            s1_v   <= 1'b0;
            s1_tag <= '0;
            s1_ax  <= '0;
            s1_ay  <= '0;
            s1_bx  <= '0;
            s1_by  <= '0;
         end else begin
            s1_v <= gany;
            if (gany) begin
               s1_tag <= gidx;
               s1_ax  <= g_ax;
               s1_ay  <= g_ay;
               s1_bx  <= g_bx;
               s1_by  <= g_by;
            end
         end
      end

      assign s1_cross = xprod(s1_ax, s1_ay, s1_bx, s1_by);

      if (PIPE == 2) begin : g_p2
         assign h_v     = s1_v;
         assign h_tag   = s1_tag;
         assign h_cross = s1_cross;
      end else begin : g_dl
         logic [PIPE-3:0]      d_v;
         logic [TW-1:0]        d_tag   [PIPE-2];
         logic signed [RW-1:0] d_cross [PIPE-2];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               d_v <= '0;
               for (int k = 0; k < PIPE - 2; k++) begin
                  d_tag[k]   <= '0;
                  d_cross[k] <= '0;
               end
            end else begin
               d_v[0]     <= s1_v;
               d_tag[0]   <= s1_tag;
               d_cross[0] <= s1_cross;
               for (int k = 1; k < PIPE - 2; k++) begin
                  d_v[k]     <= d_v[k-1];
                  d_tag[k]   <= d_tag[k-1];
                  d_cross[k] <= d_cross[k-1];
               end
            end
         end

         assign h_v     = d_v[PIPE-3];
         assign h_tag   = d_tag[PIPE-3];
         assign h_cross = d_cross[PIPE-3];
      end
   end

   // Result fields hold between responses; only rsp_valid pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid <= '0;
         rsp_cross <= '0;
         rsp_pos   <= 1'b0;
         rsp_zero  <= 1'b1;
      end else begin
         rsp_valid <= '0;
         if (h_v) begin
            rsp_valid <= NREQ'(1) << h_tag;
            rsp_cross <= h_cross;
            rsp_pos   <= !h_cross[RW-1] && (h_cross != '0);
            rsp_zero  <= (h_cross == '0);
         end
      end
   end

endmodule

// File: tb/tb_cross_arb.sv
// tb_cross_arb: randomized and directed checks of cross_arb against a
// queue-based reference model of arbitration, latency and arithmetic.
module tb_cross_arb;

   localparam int NREQ = 4;
   localparam int W    = 11;
   localparam int PIPE = 2;
   localparam int RW   = 2 * W + 1;

   logic                 clk;
   logic                 reset;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ-1:0]      req_lock;
   logic [NREQ*W-1:0]    req_ax, req_ay, req_bx, req_by;
   logic [NREQ-1:0]      rsp_valid;
   logic signed [RW-1:0] rsp_cross;
   logic                 rsp_pos;
   logic                 rsp_zero;

   cross_arb #(.NREQ(NREQ), .W(W), .PIPE(PIPE)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_lock  (req_lock),
      .req_ax    (req_ax),
      .req_ay    (req_ay),
      .req_bx    (req_bx),
      .req_by    (req_by),
      .rsp_valid (rsp_valid),
      .rsp_cross (rsp_cross),
      .rsp_pos   (rsp_pos),
      .rsp_zero  (rsp_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_run;
   int n_fail;

   // stimulus operands per requester
   int oax [NREQ];
   int oay [NREQ];
   int obx [NREQ];
   int oby [NREQ];

   // reference model state
   typedef struct {
      int     due;
      int     tag;
      longint cr;
   } ent_t;

   ent_t   q[$];
   int     cyc;
   int     m_ptr;
   int     m_lock;
   int     m_li;
   longint m_cross;

   logic [NREQ-1:0]   e_ready;
   logic [NREQ-1:0]   e_rv;
   logic signed [RW-1:0] e_cross;
   logic              e_pos;
   logic              e_zero;

   task automatic pack_ops();
      for (int i = 0; i < NREQ; i++) begin
         req_ax[i*W +: W] = oax[i][W-1:0];
         req_ay[i*W +: W] = oay[i][W-1:0];
         req_bx[i*W +: W] = obx[i][W-1:0];
         req_by[i*W +: W] = oby[i][W-1:0];
      end
   endtask

   task automatic rand_ops();
      for (int i = 0; i < NREQ; i++) begin
         oax[i] = int'($urandom_range(0, 2047)) - 1024;
         oay[i] = int'($urandom_range(0, 2047)) - 1024;
         obx[i] = int'($urandom_range(0, 2047)) - 1024;
         oby[i] = int'($urandom_range(0, 2047)) - 1024;
      end
      pack_ops();
   endtask

   task automatic model_reset();
      q.delete();
      m_ptr   = 0;
      m_lock  = 0;
      m_li    = 0;
      m_cross = 0;
   endtask

   // One clock cycle of the specified behaviour, given the inputs now applied.
   task automatic model_cycle();
      int     g;
      int     j;
      longint c;
      ent_t   e;
      g = -1;
`ifdef CROSS_ARB_LOCK_EN
      if (m_lock != 0 && req_valid[m_li]) g = m_li;
`endif
      if (g < 0) begin
         for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (g < 0 && req_valid[j]) g = j;
         end
      end
      e_ready = '0;
      if (g >= 0) e_ready[g] = 1'b1;
      e_rv = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         e_rv[e.tag] = 1'b1;
         m_cross = e.cr;
      end
      c = longint'(oax[0]);
      if (g >= 0) begin
         c = longint'(oax[g]) * longint'(oby[g])
           - longint'(obx[g]) * longint'(oay[g]);
         e.due = cyc + PIPE;
         e.tag = g;
         e.cr  = c;
         q.push_back(e);
`ifdef CROSS_ARB_LOCK_EN
         if (req_lock[g]) begin
            m_lock = 1;
            m_li   = g;
         end else begin
            m_lock = 0;
            m_ptr  = (g + 1) % NREQ;
         end
`else
         m_ptr = (g + 1) % NREQ;
`endif
      end else begin
         m_lock = 0;
      end
      e_cross = m_cross[RW-1:0];
      e_pos   = (m_cross > 0);
      e_zero  = (m_cross == 0);
      cyc++;
   endtask

   function automatic string obs_str();
      return $sformatf(
         "cyc=%0d ready=%b want %b rsp_valid=%b want %b cross=%0d want %0d pos=%b want %b zero=%b want %b",
         cyc, req_ready, e_ready, rsp_valid, e_rv, rsp_cross, e_cross,
         rsp_pos, e_pos, rsp_zero, e_zero);
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      req_valid = '0;
      req_lock  = '0;
      model_reset();
      #1;
      n_run++;
      if ({rsp_valid, rsp_cross, rsp_pos, rsp_zero} !==
          {4'b0000, 23'sd0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_outputs rsp_valid=%b cross=%0d pos=%b zero=%b want 0000/0/0/1",
                  rsp_valid, rsp_cross, rsp_pos, rsp_zero);
      end
      n_run++;
      if (req_ready !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ready_idle ready=%b want 0000", req_ready);
      end
      req_valid = 4'b0110;
      #1;
      n_run++;
      if (req_ready !== 4'b0010) begin
         n_fail++;
         $display("FAIL reset_ready_ptr0 ready=%b want 0010", req_ready);
      end
      req_valid = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_single(input string nm,
                              input int ax, input int ay,
                              input int bx, input int by,
                              input longint want,
                              input logic wpos, input logic wzero);
      logic signed [RW-1:0] w;
      w = want[RW-1:0];
      do_reset();
      for (int k = 0; k <= PIPE; k++) begin
         if (k > 0) @(negedge clk);
         oax[0] = ax; oay[0] = ay; obx[0] = bx; oby[0] = by;
         pack_ops();
         req_valid = (k == 0) ? 4'b0001 : 4'b0000;
         #1;
         model_cycle();
         n_run++;
         if ({req_ready, rsp_valid, rsp_cross, rsp_pos, rsp_zero} !==
             {e_ready, e_rv, e_cross, e_pos, e_zero}) begin
            n_fail++;
            $display("FAIL %s_model %s", nm, obs_str());
         end
         if (k == PIPE) begin
            n_run++;
            if ({rsp_valid, rsp_cross, rsp_pos, rsp_zero} !==
                {4'b0001, w, wpos, wzero}) begin
               n_fail++;
               $display("FAIL %s rsp_valid=%b cross=%0d pos=%b zero=%b want 0001/%0d/%b/%b",
                        nm, rsp_valid, rsp_cross, rsp_pos, rsp_zero, w, wpos, wzero);
            end
         end
      end
   endtask

   task automatic test_all_valid();
      do_reset();
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         rand_ops();
         req_valid = 4'b1111;
         #1;
         model_cycle();
         n_run++;
         if ({req_ready, rsp_valid, rsp_cross, rsp_pos, rsp_zero} !==
             {e_ready, e_rv, e_cross, e_pos, e_zero}) begin
            n_fail++;
            $display("FAIL all_valid_model %s", obs_str());
         end
         n_run++;
         if (req_ready !== (4'b0001 << (k % NREQ))) begin
            n_fail++;
            $display("FAIL all_valid_grant k=%0d ready=%b want idx %0d", k, req_ready, k % NREQ);
         end
         if (k >= PIPE) begin
            n_run++;
            if (rsp_valid !== (4'b0001 << ((k - PIPE) % NREQ))) begin
               n_fail++;
               $display("FAIL all_valid_rsp k=%0d rsp_valid=%b want idx %0d",
                        k, rsp_valid, (k - PIPE) % NREQ);
            end
         end
      end
   endtask

   task automatic test_lock();
      int seq [9];
      int cnt2;
`ifdef CROSS_ARB_LOCK_EN
      seq = '{2, 2, 2, 2, 2, 2, 3, 0, 1};
`else
      seq = '{2, 3, 0, 1, 2, 3, 0, 1, 2};
`endif
      cnt2 = 0;
      do_reset();
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         rand_ops();
         req_valid    = (k == 0) ? 4'b0000 : 4'b1011;
         req_valid[2] = (cnt2 < 6);
         req_lock     = '0;
         req_lock[2]  = (cnt2 < 5);
         #1;
         model_cycle();
         if (e_ready[2]) cnt2++;
         n_run++;
         if ({req_ready, rsp_valid, rsp_cross, rsp_pos, rsp_zero} !==
             {e_ready, e_rv, e_cross, e_pos, e_zero}) begin
            n_fail++;
            $display("FAIL lock_model %s", obs_str());
         end
         n_run++;
         if (req_ready !== (4'b0001 << seq[k])) begin
            n_fail++;
            $display("FAIL lock_seq k=%0d ready=%b want idx %0d", k, req_ready, seq[k]);
         end
      end
      req_lock = '0;
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         rand_ops();
         req_valid = 4'($urandom_range(0, 15));
         req_lock  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         #1;
         model_cycle();
         n_run++;
         if ({req_ready, rsp_valid, rsp_cross, rsp_pos, rsp_zero} !==
             {e_ready, e_rv, e_cross, e_pos, e_zero}) begin
            n_fail++;
            $display("FAIL random_model %s", obs_str());
         end
      end
      req_lock = '0;
   endtask

   task automatic test_reset_inflight();
      do_reset();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         rand_ops();
         req_valid = (k == 0) ? 4'b0001 : 4'b0100;
         #1;
         model_cycle();
         n_run++;
         if ({req_ready, rsp_valid} !== {e_ready, e_rv}) begin
            n_fail++;
            $display("FAIL inflight_accept %s", obs_str());
         end
      end
      #1;
      reset     = 1'b1;
      req_valid = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 4 + PIPE; k++) begin
         @(negedge clk);
         rand_ops();
         req_valid = (k == 3) ? 4'b1010 : 4'b0000;
         #1;
         model_cycle();
         n_run++;
         if ({req_ready, rsp_valid, rsp_cross, rsp_pos, rsp_zero} !==
             {e_ready, e_rv, e_cross, e_pos, e_zero}) begin
            n_fail++;
            $display("FAIL inflight_model %s", obs_str());
         end
         if (k == 3) begin
            n_run++;
            if (req_ready !== 4'b0010) begin
               n_fail++;
               $display("FAIL inflight_ptr0 ready=%b want 0010", req_ready);
            end
         end
         n_run++;
         if (rsp_valid !== ((k == 3 + PIPE) ? 4'b0010 : 4'b0000)) begin
            n_fail++;
            $display("FAIL inflight_rsp k=%0d rsp_valid=%b want %b", k, rsp_valid,
                     (k == 3 + PIPE) ? 4'b0010 : 4'b0000);
         end
      end
   endtask

   initial begin
      n_run     = 0;
      n_fail    = 0;
      cyc       = 0;
      reset     = 1'b1;
      req_valid = '0;
      req_lock  = '0;
      for (int i = 0; i < NREQ; i++) begin
         oax[i] = 0; oay[i] = 0; obx[i] = 0; oby[i] = 0;
      end
      pack_ops();
      model_reset();
      test_reset();
      test_single("basic", 3, 0, 0, 4, 64'sd12, 1'b1, 1'b0);
      test_single("extreme", 1023, 1023, -1024, 1023, 64'sd2094081, 1'b1, 1'b0);
      test_single("extreme_swap", -1024, 1023, 1023, 1023, -64'sd2094081, 1'b0, 1'b0);
      test_single("collinear", 2, 4, 1, 2, 64'sd0, 1'b0, 1'b1);
      test_all_valid();
      test_lock();
      test_random();
      test_reset_inflight();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
